// File: rtl/traffic_pkg.sv
// Shared phase encodings, light patterns and default timing for the
// intersection phase scheduler.
package traffic_pkg;

   typedef enum logic [1:0] {
      S_AG = 2'b00,
      S_AY = 2'b01,
      S_BG = 2'b10,
      S_BY = 2'b11
   } phase_t;

   // LED order is {A_R,A_Y,A_G,B_R,B_Y,B_G}
   localparam logic [5:0] LED_AG     = 6'b001100;
   localparam logic [5:0] LED_AY     = 6'b010100;
   localparam logic [5:0] LED_BG     = 6'b100001;
   localparam logic [5:0] LED_BY     = 6'b100010;
   localparam logic [5:0] LED_ALLRED = 6'b100100;

   localparam int DEF_AG_TIME   = 27;
   localparam int DEF_BG_TIME   = 17;
   localparam int DEF_Y_TIME    = 3;
   localparam int DEF_MIN_GREEN = 5;
   localparam int DEF_W         = 6;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter holding the remaining TICKs of the current phase.
// Freeze outranks load and decrement so an emergency hold keeps the count.
module phase_timer #(
   parameter int             W       = 6,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec_en,
   input  logic         i_freeze,
   output logic [W-1:0] o_cnt,
   output logic         o_is_one
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= RST_VAL;
      end else if (i_freeze) begin
         r_cnt <= r_cnt;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec_en) begin
         r_cnt <= r_cnt - ONE;
      end
   end

   assign o_cnt    = r_cnt;
   assign o_is_one = (r_cnt == ONE);

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road phase scheduler: AG -> AY -> BG -> BY with sensor-driven early
// handover / green hold, emergency all-red freeze, and display decoding.
module traffic_phase_sched
   import traffic_pkg::*;
#(
   parameter int AG_TIME   = DEF_AG_TIME,
   parameter int BG_TIME   = DEF_BG_TIME,
   parameter int Y_TIME    = DEF_Y_TIME,
   parameter int MIN_GREEN = DEF_MIN_GREEN,
   parameter int W         = DEF_W
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         TICK,
   input  logic         AS,
   input  logic         BS,
   input  logic         EMG,
   output logic [1:0]   state,
   output logic [5:0]   led,
   output logic [W-1:0] A_time,
   output logic [W-1:0] B_time,
   output logic         phase_done
);

   localparam int MAX_GREEN = (AG_TIME > BG_TIME) ? AG_TIME : BG_TIME;

   generate
      if (!(MIN_GREEN >= 1 && MIN_GREEN < AG_TIME && MIN_GREEN < BG_TIME &&
            Y_TIME >= 1 && (MAX_GREEN + Y_TIME) <= ((1 << W) - 1))) begin : g_bad_params
         $error("traffic_phase_sched: illegal timing parameters");
      end
   endgenerate

   localparam logic [W-1:0] C_AG  = W'(AG_TIME);
   localparam logic [W-1:0] C_BG  = W'(BG_TIME);
   localparam logic [W-1:0] C_Y   = W'(Y_TIME);
   localparam logic [W-1:0] C_MIN = W'(MIN_GREEN);

   phase_t       r_state;
   phase_t       w_next_state;
   logic         r_phase_done;
   logic         w_load;
   logic         w_dec;
   logic [W-1:0] w_load_val;
   logic [W-1:0] w_cnt;
   logic         w_is_one;
   logic         w_mine;
   logic         w_other;
   logic [W-1:0] w_green_len;
   logic [W-1:0] w_elapsed;

   phase_timer #(
      .W       (W),
      .RST_VAL (C_AG)
   ) u_timer (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec_en   (w_dec),
      .i_freeze   (EMG),
      .o_cnt      (w_cnt),
      .o_is_one   (w_is_one)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_AG;
         r_phase_done <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_phase_done <= (w_next_state != r_state);
      end
   end

   // Green phases see their own road as "mine"; holding at cnt==1 simply
   // suppresses both load and decrement.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_load_val   = C_Y;
      w_dec        = 1'b0;
      w_mine       = (r_state == S_AG) ? AS : BS;
      w_other      = (r_state == S_AG) ? BS : AS;
      w_green_len  = (r_state == S_AG) ? C_AG : C_BG;
      w_elapsed    = w_green_len - w_cnt;
      if (TICK && !EMG) begin
         unique case (r_state)
            S_AG, S_BG: begin
               if ((!w_mine && w_other && (w_elapsed >= C_MIN)) ||
                   (w_is_one && !(w_mine && !w_other))) begin
                  w_next_state = (r_state == S_AG) ? S_AY : S_BY;
                  w_load       = 1'b1;
                  w_load_val   = C_Y;
               end else if (!w_is_one) begin
                  w_dec = 1'b1;
               end
            end
            S_AY: begin
               if (w_is_one) begin
                  w_next_state = S_BG;
                  w_load       = 1'b1;
                  w_load_val   = C_BG;
               end else begin
                  w_dec = 1'b1;
               end
            end
            S_BY: begin
               if (w_is_one) begin
                  w_next_state = S_AG;
                  w_load       = 1'b1;
                  w_load_val   = C_AG;
               end else begin
                  w_dec = 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      led    = LED_AG;
      A_time = w_cnt;
      B_time = w_cnt;
      if (EMG) begin
         led    = LED_ALLRED;
         A_time = '0;
         B_time = '0;
      end else begin
         unique case (r_state)
            S_AG: begin
               led    = LED_AG;
               B_time = w_cnt + C_Y;
            end
            S_AY: led = LED_AY;
            S_BG: begin
               led    = LED_BG;
               A_time = w_cnt + C_Y;
            end
            S_BY: led = LED_BY;
         endcase
      end
   end

   assign state      = r_state;
   assign phase_done = r_phase_done;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench: stimulus pushes predicted outputs from a phase/seconds
// model, a negedge monitor pops and compares them against the DUT.
module tb_traffic_phase_sched;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       TICK = 1'b0;
   logic       AS = 1'b0;
   logic       BS = 1'b0;
   logic       EMG = 1'b0;
   logic [1:0] state;
   logic [5:0] led;
   logic [5:0] A_time;
   logic [5:0] B_time;
   logic       phase_done;

   always #5 CLK = ~CLK;

   traffic_phase_sched dut (
      .CLK        (CLK),
      .RST        (RST),
      .TICK       (TICK),
      .AS         (AS),
      .BS         (BS),
      .EMG        (EMG),
      .state      (state),
      .led        (led),
      .A_time     (A_time),
      .B_time     (B_time),
      .phase_done (phase_done)
   );

   typedef struct {
      logic [1:0] st;
      logic [5:0] ld;
      logic [5:0] at;
      logic [5:0] bt;
      logic       pd;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   stimDone = 1'b0;

   // Model: phase index 0..3 (AG,AY,BG,BY) and seconds remaining.
   int         mPhase = 0;
   int         mRem = 27;
   bit         mPd = 1'b0;
   bit         mValid = 1'b0;
   int         dur[4] = '{27, 3, 17, 3};
   logic [5:0] ledTab[4] = '{6'b001100, 6'b010100, 6'b100001, 6'b100010};

   function automatic void advance();
      mPhase = (mPhase + 1) % 4;
      mRem   = dur[mPhase];
      mPd    = 1'b1;
   endfunction

   function automatic void modelStep(bit r, bit t, bit a, bit b, bit e);
      bit mine;
      bit other;
      int served;
      if (r) begin
         mPhase = 0;
         mRem   = 27;
         mPd    = 1'b0;
         mValid = 1'b1;
         return;
      end
      mPd = 1'b0;
      if (!mValid || e || !t) return;
      if (mPhase == 1 || mPhase == 3) begin
         if (mRem == 1) advance();
         else mRem--;
         return;
      end
      mine   = (mPhase == 0) ? a : b;
      other  = (mPhase == 0) ? b : a;
      served = dur[mPhase] - mRem;
      if (mRem == 1 && mine && !other) return;
      if ((!mine && other && served >= 5) || mRem == 1) advance();
      else mRem--;
   endfunction

   function automatic exp_t expected(bit e);
      exp_t x;
      x.st = 2'(mPhase);
      x.pd = mPd;
      if (e) begin
         x.ld = 6'b100100;
         x.at = 6'd0;
         x.bt = 6'd0;
      end else begin
         x.ld = ledTab[mPhase];
         x.at = 6'(mRem + ((mPhase == 2) ? 3 : 0));
         x.bt = 6'(mRem + ((mPhase == 0) ? 3 : 0));
      end
      return x;
   endfunction

   task automatic applyStimulus(input bit r, input bit t, input bit a, input bit b, input bit e);
      RST  = r;
      TICK = t;
      AS   = a;
      BS   = b;
      EMG  = e;
      if (mValid) sbq.push_back(expected(e));
      @(posedge CLK);
      #1;
      modelStep(r, t, a, b, e);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   always @(negedge CLK) begin
      if (sbq.size() > 0) begin
         exp_t x;
         x = sbq.pop_front();
         checkOutput("state", {6'b0, state}, {6'b0, x.st});
         checkOutput("led", {2'b0, led}, {2'b0, x.ld});
         checkOutput("A_time", {2'b0, A_time}, {2'b0, x.at});
         checkOutput("B_time", {2'b0, B_time}, {2'b0, x.bt});
         checkOutput("phase_done", {7'b0, phase_done}, {7'b0, x.pd});
      end
   end

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic runTicks(input int n, input bit a, input bit b, input int period);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b1, a, b, 1'b0);
         for (int j = 1; j < period; j++) applyStimulus(1'b0, 1'b0, a, b, 1'b0);
      end
   endtask

   task automatic runToPhase(input int p, input int rem);
      for (int k = 0; k < 120 && !(mPhase == p && (rem == 0 || mRem == rem)); k++)
         runTicks(1, 1'b1, 1'b1, 2);
   endtask

   initial begin
      bit ra;
      bit rb;
      bit re;

      // Full cycle with both sensors high
      doReset();
      runTicks(55, 1'b1, 1'b1, 4);

      // Early handover A -> B
      doReset();
      runTicks(8, 1'b0, 1'b1, 4);

      // Green hold in BG, then release
      doReset();
      runToPhase(2, 0);
      runTicks(25, 1'b0, 1'b1, 2);
      runTicks(3, 1'b0, 1'b0, 2);

      // Emergency freeze in AG at 12 seconds left
      doReset();
      runToPhase(0, 12);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      runTicks(3, 1'b1, 1'b1, 3);

      // Sensor toggling during yellow
      doReset();
      runToPhase(1, 0);
      for (int i = 0; i < 4; i++) runTicks(1, 1'(i % 2), 1'(~i % 2), 2);
      runToPhase(3, 0);
      for (int i = 0; i < 4; i++) runTicks(1, 1'(i % 2), 1'b1, 2);

      // Reset mid-BY with a coincident TICK
      doReset();
      runToPhase(3, 2);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      runTicks(3, 1'b1, 1'b1, 2);

      // Randomised traffic
      ra = 1'b0;
      rb = 1'b0;
      re = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(15) == 0) ra = ~ra;
         if ($urandom_range(15) == 0) rb = ~rb;
         if ($urandom_range(re ? 7 : 150) == 0) re = ~re;
         applyStimulus(1'($urandom_range(599) == 0), 1'($urandom_range(3) == 0), ra, rb, re);
      end

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge CLK);
      @(posedge CLK);
      if (sbq.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
      end
      stimDone = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
